// File: rtl/rst_seq_gen.sv
// Staged reset sequencer: debounces the push-button, releases RST_N channels on
// programmed delays, then waits for host acknowledge (or timeout) before releasing the slot.
module rst_seq_gen #(
   parameter int                      NUM_CH      = 4,
   parameter int                      CNT_W       = 16,
   parameter logic [CNT_W-1:0]        DEBOUNCE    = 16'h00FF,
   parameter logic [NUM_CH*CNT_W-1:0] STAGE_DLY   = {16'hFFF0, 16'h0400, 16'h0100, 16'h00FF},
   parameter logic [CNT_W-1:0]        ACK_TIMEOUT = 16'h1000
) (
   input  logic              RST_CPLD_CLK,
   input  logic              RST_CPLD_RST,
   input  logic              PUSH_RST_,
   input  logic              SW_RST_REQ,
   input  logic              RST_OUT_,
   output logic [NUM_CH-1:0] RST_N,
   output logic              SLOT_RST_,
   output logic              SEQ_DONE,
   output logic              ACK_TO,
   output logic [2:0]        STATE
);

   typedef enum logic [2:0] {
      ST_HOLD     = 3'd0,
      ST_DEBOUNCE = 3'd1,
      ST_SEQUENCE = 3'd2,
      ST_WAIT_ACK = 3'd3,
      ST_RUN      = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W:0]   CNT1_EXT = {{CNT_W{1'b0}}, 1'b1};

   logic              push_meta_r, push_sync_r;
   logic              ack_meta_r, ack_sync_r;
   state_t            state_r, state_nxt_s;
   logic [CNT_W-1:0]  cnt_r, cnt_nxt_s, cnt_inc_s;
   logic [NUM_CH-1:0] rst_n_r, rst_n_nxt_s, hit_s;
   logic              slot_r, slot_nxt_s;
   logic              done_r, done_nxt_s;
   logic              ack_to_r, ack_to_nxt_s;
   logic              deb_done_s, to_done_s;

   // Two-flop synchronizers for the asynchronous button and host acknowledge
   always_ff @(posedge RST_CPLD_CLK or posedge RST_CPLD_RST) begin
      if (RST_CPLD_RST) begin
         push_meta_r <= 1'b0;
         push_sync_r <= 1'b0;
         ack_meta_r  <= 1'b1;
         ack_sync_r  <= 1'b1;
      end else begin
         push_meta_r <= PUSH_RST_;
         push_sync_r <= push_meta_r;
         ack_meta_r  <= RST_OUT_;
         ack_sync_r  <= ack_meta_r;
      end
   end

   // Saturating increment and the per-channel / terminal-count compares
   assign cnt_inc_s  = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
   assign deb_done_s = ({1'b0, cnt_r} + CNT1_EXT) >= {1'b0, DEBOUNCE};
   assign to_done_s  = ({1'b0, cnt_r} + CNT1_EXT) >= {1'b0, ACK_TIMEOUT};

   always_comb begin
      hit_s = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         hit_s[k] = (cnt_r >= STAGE_DLY[k*CNT_W +: CNT_W]);
      end
   end

   // Next-state and next-output logic; a low button overrides everything
   always_comb begin
      state_nxt_s  = state_r;
      cnt_nxt_s    = cnt_r;
      rst_n_nxt_s  = rst_n_r;
      slot_nxt_s   = slot_r;
      done_nxt_s   = 1'b0;
      ack_to_nxt_s = ack_to_r;
      if (!push_sync_r && (state_r != ST_HOLD)) begin
         state_nxt_s  = ST_HOLD;
         cnt_nxt_s    = '0;
         rst_n_nxt_s  = '0;
         slot_nxt_s   = 1'b0;
         ack_to_nxt_s = 1'b0;
      end else begin
         case (state_r)
            ST_HOLD: begin
               cnt_nxt_s   = '0;
               rst_n_nxt_s = '0;
               slot_nxt_s  = 1'b0;
               if (push_sync_r) state_nxt_s = ST_DEBOUNCE;
               else             state_nxt_s = ST_HOLD;
            end
            ST_DEBOUNCE: begin
               rst_n_nxt_s = '0;
               slot_nxt_s  = 1'b0;
               if (deb_done_s) begin
                  state_nxt_s = ST_SEQUENCE;
                  cnt_nxt_s   = '0;
               end else begin
                  cnt_nxt_s   = cnt_inc_s;
               end
            end
            ST_SEQUENCE: begin
               if (&rst_n_r) begin
                  state_nxt_s = ST_WAIT_ACK;
                  cnt_nxt_s   = '0;
               end else begin
                  cnt_nxt_s   = cnt_inc_s;
                  rst_n_nxt_s = rst_n_r | hit_s;
               end
            end
            ST_WAIT_ACK: begin
               // Acknowledge wins over a coinciding timeout
               if (!ack_sync_r) begin
                  state_nxt_s = ST_RUN;
                  cnt_nxt_s   = '0;
                  slot_nxt_s  = 1'b1;
                  done_nxt_s  = 1'b1;
               end else if (to_done_s) begin
                  state_nxt_s  = ST_RUN;
                  cnt_nxt_s    = '0;
                  slot_nxt_s   = 1'b1;
                  done_nxt_s   = 1'b1;
                  ack_to_nxt_s = 1'b1;
               end else begin
                  cnt_nxt_s    = cnt_inc_s;
               end
            end
            ST_RUN: begin
               cnt_nxt_s = '0;
               if (SW_RST_REQ) begin
                  state_nxt_s = ST_HOLD;
                  rst_n_nxt_s = '0;
                  slot_nxt_s  = 1'b0;
               end else begin
                  done_nxt_s  = 1'b1;
               end
            end
            default: begin
               state_nxt_s = ST_HOLD;
               cnt_nxt_s   = '0;
               rst_n_nxt_s = '0;
               slot_nxt_s  = 1'b0;
            end
         endcase
      end
   end

   // State, counter and registered outputs
   always_ff @(posedge RST_CPLD_CLK or posedge RST_CPLD_RST) begin
      if (RST_CPLD_RST) begin
         state_r  <= ST_HOLD;
         cnt_r    <= '0;
         rst_n_r  <= '0;
         slot_r   <= 1'b0;
         done_r   <= 1'b0;
         ack_to_r <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         cnt_r    <= cnt_nxt_s;
         rst_n_r  <= rst_n_nxt_s;
         slot_r   <= slot_nxt_s;
         done_r   <= done_nxt_s;
         ack_to_r <= ack_to_nxt_s;
      end
   end

   assign RST_N     = rst_n_r;
   assign SLOT_RST_ = slot_r;
   assign SEQ_DONE  = done_r;
   assign ACK_TO    = ack_to_r;
   assign STATE     = state_r;

endmodule
